imem_port_arbiter: RTL and testbench

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

---
 rtl/imem_arb_pkg.sv | 18 +
 rtl/imem_port_arbiter_dbg_wr_fifo.sv | 63 ++++++
 rtl/imem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FORCE = 2'd1,
        ST_LOAD  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dbg_wr_t;

endpackage

// File: rtl/imem_port_arbiter_dbg_wr_fifo.sv
// Synchronous FIFO buffering debug writes; exposes full, empty and count.
module dbg_wr_fifo
    import imem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push_i,
    input  dbg_wr_t                    wdata_i,
    input  logic                       pop_i,
    output dbg_wr_t                    rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    dbg_wr_t         mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Push is refused when full and pop when empty, so the count never wraps.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; reset discards all pending entries.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates one instruction-memory port between frontend fetches and
// buffered debug writes, with starvation forcing and a debug load mode.
// Optional fetch-stall performance counter: define IMEM_ARB_PERF_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned DBG_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              core_stall,
    input  logic              dbg_mode,
    input  logic              dbg_wr_valid,
    output logic              dbg_wr_ready,
    input  logic [ADDR_W-1:0] dbg_wr_addr,
    input  logic [DATA_W-1:0] dbg_wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       fetch_stall_cnt
);

    localparam int unsigned CW = $clog2(DBG_FIFO_DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e      state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            active_q;
    logic            rvalid_q;
    logic            gnt, pop, push;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count, count_nxt;
    dbg_wr_t         head, wr_entry;

    assign wr_entry     = '{addr: dbg_wr_addr, data: dbg_wr_data};
    // active_q holds everything quiet until the first edge after reset release.
    assign dbg_wr_ready = active_q && !fifo_full;
    assign push         = dbg_wr_valid && dbg_wr_ready;

    dbg_wr_fifo #(
        .DEPTH (DBG_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Grant/pop selection, starvation tracking and next-state decision.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        gnt       = 1'b0;
        pop       = 1'b0;
        count_nxt = fifo_count;
        if (active_q) begin
            case (state_q)
                ST_RUN: begin
                    if (fetch_req) begin
                        gnt = 1'b1;
                    end else begin
                        pop = !fifo_empty;
                    end
                end
                ST_FORCE,
                ST_LOAD: pop = !fifo_empty;
                default: pop = 1'b0;
            endcase

            if (pop) begin
                starve_d = '0;
            end else if (state_q == ST_RUN && gnt && !fifo_empty &&
                         starve_q < SW'(STARVE_LIMIT)) begin
                starve_d = starve_q + 1'b1;
            end

            // Transitions look at post-cycle occupancy and starvation so the
            // forced write or the return to RUN lands in the very next cycle.
            count_nxt = fifo_count + CW'(push) - CW'(pop);
            case (state_q)
                ST_RUN: begin
                    if (dbg_mode) begin
                        state_d = ST_LOAD;
                    end else if (count_nxt == CW'(DBG_FIFO_DEPTH) ||
                                 starve_d == SW'(STARVE_LIMIT)) begin
                        state_d = ST_FORCE;
                    end
                end
                ST_FORCE: state_d = dbg_mode ? ST_LOAD : ST_RUN;
                ST_LOAD: begin
                    if (!dbg_mode && count_nxt == '0) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State, starvation counter, reset-release flag and read-valid pipeline.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_RUN;
            starve_q <= '0;
            active_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            active_q <= 1'b1;
            rvalid_q <= gnt;
        end
    end

    assign fetch_gnt    = gnt;
    assign fetch_rvalid = rvalid_q;
    assign fetch_rdata  = rvalid_q ? mem_rdata : '0;
    assign core_stall   = active_q && ((state_q == ST_LOAD) || (fetch_req && !gnt));
    assign mem_en       = gnt || pop;
    assign mem_we       = pop;
    assign mem_addr     = pop ? head.addr : (gnt ? fetch_addr : '0);
    assign mem_wdata    = pop ? head.data : '0;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    // Counts fetch-denied cycles, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt_q <= '0;
        end else if (active_q && fetch_req && !gnt) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
`else
    assign fetch_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter.
module tb_imem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_rvalid, core_stall;
    logic [31:0] fetch_rdata;
    logic        dbg_mode = 1'b0;
    logic        dbg_wr_valid = 1'b0;
    logic        dbg_wr_ready;
    logic [31:0] dbg_wr_addr = '0, dbg_wr_data = '0;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] fetch_stall_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        dm;
        logic        wv;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        gnt;
        logic        en;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [10];

    imem_port_arbiter #(
        .DBG_FIFO_DEPTH (4),
        .STARVE_LIMIT   (8)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_gnt       (fetch_gnt),
        .fetch_rvalid    (fetch_rvalid),
        .fetch_rdata     (fetch_rdata),
        .core_stall      (core_stall),
        .dbg_mode        (dbg_mode),
        .dbg_wr_valid    (dbg_wr_valid),
        .dbg_wr_ready    (dbg_wr_ready),
        .dbg_wr_addr     (dbg_wr_addr),
        .dbg_wr_data     (dbg_wr_data),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .fetch_stall_cnt (fetch_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: read data one cycle after a read enable, else zero.
    always @(posedge clk) begin
        mem_rdata <= (mem_en && !mem_we) ? f(mem_addr) : 32'h0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs mid-cycle, advance.
    task automatic apply(input vec_t v, input string nm);
        fetch_req    = v.req;
        fetch_addr   = v.addr;
        dbg_mode     = v.dm;
        dbg_wr_valid = v.wv;
        dbg_wr_addr  = v.wa;
        dbg_wr_data  = v.wd;
        @(negedge clk);
        chk({nm, ".gnt"},    32'(fetch_gnt),    32'(v.gnt));
        chk({nm, ".en"},     32'(mem_en),       32'(v.en));
        chk({nm, ".we"},     32'(mem_we),       32'(v.we));
        chk({nm, ".addr"},   mem_addr,          v.maddr);
        chk({nm, ".wdata"},  mem_wdata,         v.wdata);
        chk({nm, ".stall"},  32'(core_stall),   32'(v.stall));
        chk({nm, ".ready"},  32'(dbg_wr_ready), 32'(v.ready));
        chk({nm, ".rvalid"}, 32'(fetch_rvalid), 32'(v.rv));
        chk({nm, ".rdata"},  fetch_rdata,       v.rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0; fetch_addr = '0; dbg_mode = 1'b0;
        dbg_wr_valid = 1'b0; dbg_wr_addr = '0; dbg_wr_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // req, addr, dm, wv, wa, wd, gnt, en, we, maddr, wdata, stall, ready, rv, rd
        vecs[0] = '{H, 32'd0, L, L, Z, Z, H, H, L, 32'd0, Z, L, H, L, Z};
        vecs[1] = '{H, 32'd1, L, L, Z, Z, H, H, L, 32'd1, Z, L, H, H, f(32'd0)};
        vecs[2] = '{H, 32'd2, L, L, Z, Z, H, H, L, 32'd2, Z, L, H, H, f(32'd1)};
        vecs[3] = '{H, 32'd3, L, L, Z, Z, H, H, L, 32'd3, Z, L, H, H, f(32'd2)};
        vecs[4] = '{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, H, f(32'd3)};
        vecs[5] = '{L, Z, L, H, 32'h10, 32'h11, L, L, L, Z, Z, L, H, L, Z};
        vecs[6] = '{L, Z, L, L, Z, Z, L, H, H, 32'h10, 32'h11, L, H, L, Z};
        vecs[7] = '{H, 32'd7, L, H, 32'h20, 32'h22, H, H, L, 32'd7, Z, L, H, L, Z};
        vecs[8] = '{L, Z, L, L, Z, Z, L, H, H, 32'h20, 32'h22, L, H, H, f(32'd7)};
        vecs[9] = '{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, L, Z};

        // Reset: outputs quiet even with requests present.
        fetch_req = 1'b1; fetch_addr = 32'h44; dbg_wr_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.gnt",    32'(fetch_gnt),    Z);
        chk("rst.en",     32'(mem_en),       Z);
        chk("rst.we",     32'(mem_we),       Z);
        chk("rst.addr",   mem_addr,          Z);
        chk("rst.ready",  32'(dbg_wr_ready), Z);
        chk("rst.stall",  32'(core_stall),   Z);
        chk("rst.rvalid", 32'(fetch_rvalid), Z);
        chk("rst.rdata",  fetch_rdata,       Z);
        chk("rst.scnt",   fetch_stall_cnt,   Z);
        idle_inputs();
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back fetches, idle, opportunistic debug writes.
        for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("tab%0d", i));

        // Starvation: single write forced on the 9th cycle after push.
        apply('{H, 32'h100, L, H, 32'd5, 32'hDEADBEEF, H, H, L, 32'h100, Z, L, H, L, Z}, "stv.push");
        for (int k = 1; k <= 8; k++)
            apply('{H, 32'h100 + k, L, L, Z, Z, H, H, L, 32'h100 + k, Z, L, H, H, f(32'h100 + k - 1)},
                  $sformatf("stv.c%0d", k));
        apply('{H, 32'h109, L, L, Z, Z, L, H, H, 32'd5, 32'hDEADBEEF, H, H, H, f(32'h108)}, "stv.force");
        apply('{H, 32'h10A, L, L, Z, Z, H, H, L, 32'h10A, Z, L, H, L, Z}, "stv.after");
        apply('{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, H, f(32'h10A)}, "stv.idle");

        // Full FIFO: ready drops, FORCE pops, ready back next cycle.
        for (int i = 0; i < 4; i++)
            apply('{H, 32'h300 + i, L, H, 32'h40 + i, 32'h400 + i, H, H, L, 32'h300 + i, Z, L, H,
                    (i != 0), (i != 0) ? f(32'h300 + i - 1) : Z}, $sformatf("full.push%0d", i));
        apply('{H, 32'h304, L, H, 32'h50, 32'h500, L, H, H, 32'h40, 32'h400, H, L, H, f(32'h303)}, "full.force");
        apply('{H, 32'h305, L, L, Z, Z, H, H, L, 32'h305, Z, L, H, L, Z}, "full.ready");
        for (int i = 1; i < 4; i++)
            apply('{L, Z, L, L, Z, Z, L, H, H, 32'h40 + i, 32'h400 + i, L, H,
                    (i == 1), (i == 1) ? f(32'h305) : Z}, $sformatf("full.drain%0d", i));
        apply('{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, L, Z}, "full.idle");

        // Debug load: 3 queued writes drained back to back, then fetch resumes.
        for (int i = 0; i < 3; i++)
            apply('{H, 32'h500 + i, L, H, 32'h60 + i, 32'h600 + i, H, H, L, 32'h500 + i, Z, L, H,
                    (i != 0), (i != 0) ? f(32'h500 + i - 1) : Z}, $sformatf("load.push%0d", i));
        apply('{H, 32'h503, H, L, Z, Z, H, H, L, 32'h503, Z, L, H, H, f(32'h502)}, "load.enter");
        apply('{H, 32'h504, L, L, Z, Z, L, H, H, 32'h60, 32'h600, H, H, H, f(32'h503)}, "load.w0");
        apply('{H, 32'h505, L, L, Z, Z, L, H, H, 32'h61, 32'h601, H, H, L, Z}, "load.w1");
        apply('{H, 32'h506, L, L, Z, Z, L, H, H, 32'h62, 32'h602, H, H, L, Z}, "load.w2");
        apply('{H, 32'h507, L, L, Z, Z, H, H, L, 32'h507, Z, L, H, L, Z}, "load.resume");
        apply('{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, H, f(32'h507)}, "load.idle");

        // Reset mid-LOAD with two entries pending.
        for (int i = 0; i < 3; i++)
            apply('{H, 32'h700 + i, L, H, 32'h70 + i, 32'h700 + i, H, H, L, 32'h700 + i, Z, L, H,
                    (i != 0), (i != 0) ? f(32'h700 + i - 1) : Z}, $sformatf("mrst.push%0d", i));
        apply('{H, 32'h703, H, L, Z, Z, H, H, L, 32'h703, Z, L, H, H, f(32'h702)}, "mrst.enter");
        apply('{H, 32'h704, H, L, Z, Z, L, H, H, 32'h70, 32'h700, H, H, H, f(32'h703)}, "mrst.w0");
        idle_inputs();
        nrst = 1'b0;
        #1;
        chk("mrst.en",    32'(mem_en),       Z);
        chk("mrst.ready", 32'(dbg_wr_ready), Z);
        chk("mrst.stall", 32'(core_stall),   Z);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            apply('{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, L, Z}, $sformatf("mrst.quiet%0d", i));
        chk("mrst.scnt", fetch_stall_cnt, Z);
        apply('{H, 32'h708, L, L, Z, Z, H, H, L, 32'h708, Z, L, H, L, Z}, "mrst.fetch");
        apply('{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, H, f(32'h708)}, "mrst.idle");

        // Five denied fetch cycles in LOAD for the stall counter.
        apply('{H, 32'h900, H, L, Z, Z, H, H, L, 32'h900, Z, L, H, L, Z}, "perf.enter");
        for (int i = 1; i <= 4; i++)
            apply('{H, 32'h900, H, L, Z, Z, L, L, L, Z, Z, H, H,
                    (i == 1), (i == 1) ? f(32'h900) : Z}, $sformatf("perf.deny%0d", i));
        apply('{H, 32'h900, L, L, Z, Z, L, L, L, Z, Z, H, H, L, Z}, "perf.deny5");
        apply('{L, Z, L, L, Z, Z, L, L, L, Z, Z, L, H, L, Z}, "perf.idle");
`ifdef IMEM_ARB_PERF_EN
        chk("perf.scnt", fetch_stall_cnt, 32'd5);
`else
        chk("perf.scnt", fetch_stall_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
